// File: rtl/tdes_pkg.sv
// Shared types, DES permutation tables and helper functions
// for the 3DES round-subkey scheduler.
package tdes_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_ROUND,
        S_DONE
    } state_t;

    localparam int KEY_W  = 64;
    localparam int K1_LSB = 128;
    localparam int K2_LSB = 64;
    localparam int K3_LSB = 0;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int SHIFT_T [16] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // Table entries are 1-based positions counted from the MSB.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = k[6'(64 - PC1_T[i])];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
        end
        return r;
    endfunction

    function automatic logic [27:0] rotl28(
        input logic [27:0] x,
        input logic        two
    );
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(
        input logic [27:0] x,
        input logic        two
    );
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_cd_reg.sv
// Registered DES C/D key halves with load and bidirectional
// rotate; presents the PC2 selection of the current state.
module des_cd_reg
    import tdes_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [55:0] i_load_cd,
    input  logic        i_load_rotl,
    input  logic        i_rot,
    input  logic        i_rot_left,
    input  logic        i_rot_two,
    output logic [47:0] o_pc2
);

    logic [55:0] r_cd;
    logic [27:0] w_c;
    logic [27:0] w_d;

    assign w_c   = r_cd[55:28];
    assign w_d   = r_cd[27:0];
    assign o_pc2 = pc2(r_cd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cd <= '0;
        end else if (i_load) begin
            if (i_load_rotl) begin
                r_cd <= {rotl28(i_load_cd[55:28], 1'b0),
                         rotl28(i_load_cd[27:0], 1'b0)};
            end else begin
                r_cd <= i_load_cd;
            end
        end else if (i_rot) begin
            if (i_rot_left) begin
                r_cd <= {rotl28(w_c, i_rot_two), rotl28(w_d, i_rot_two)};
            end else begin
                r_cd <= {rotr28(w_c, i_rot_two), rotr28(w_d, i_rot_two)};
            end
        end
    end

endmodule

// File: rtl/tdes_key_sched.sv
// 3DES EDE subkey streamer: emits 48 DES round subkeys over a
// valid/ready handshake with pass and round tags.
module tdes_key_sched
    import tdes_pkg::*;
#(
    parameter int NUM_PASSES = 3,
    parameter int ROUNDS     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [191:0] keys,
    input  logic         decrypt,
    input  logic         abort,
    input  logic         subkey_ready,
    output logic [47:0]  subkey,
    output logic         subkey_valid,
    output logic [3:0]   round_idx,
    output logic [1:0]   pass_idx,
    output logic         pass_decrypt,
    output logic         last_round,
    output logic         busy,
    output logic         done
);

    state_t       r_state;
    logic [191:0] r_keys;
    logic         r_dec;
    logic [1:0]   r_pass;
    logic [3:0]   r_round;

    logic         w_valid;
    logic         w_xfer;
    logic         w_last_rnd;
    logic         w_last_pass;
    logic         w_pass_dec;
    logic         w_rot;
    logic         w_two;
    logic [3:0]   w_sidx;
    logic [63:0]  w_pass_key;
    logic [47:0]  w_pc2;

    assign w_valid     = (r_state == S_ROUND);
    assign w_xfer      = w_valid && subkey_ready && !abort;
    assign w_last_rnd  = (r_round == 4'(ROUNDS - 1));
    assign w_last_pass = (r_pass == 2'(NUM_PASSES - 1));
    assign w_pass_dec  = r_dec ^ (r_pass == 2'd1);
    assign w_rot       = w_xfer && !w_last_rnd;

    // Decrypt passes walk the schedule backwards from C16/D16 == C0/D0.
    assign w_sidx = w_pass_dec ? 4'(4'd15 - r_round)
                               : 4'(r_round + 4'd1);
    assign w_two  = (SHIFT_T[w_sidx] == 2);

    always_comb begin
        w_pass_key = r_keys[K3_LSB +: KEY_W];
        if (r_pass == 2'd1) begin
            w_pass_key = r_keys[K2_LSB +: KEY_W];
        end else if ((r_pass == 2'd0) != r_dec) begin
            w_pass_key = r_keys[K1_LSB +: KEY_W];
        end
    end

    des_cd_reg u_cd (
        .clk         (clk),
        .rst         (rst),
        .i_load      (r_state == S_PREP),
        .i_load_cd   (pc1(w_pass_key)),
        .i_load_rotl (!w_pass_dec),
        .i_rot       (w_rot),
        .i_rot_left  (!w_pass_dec),
        .i_rot_two   (w_two),
        .o_pc2       (w_pc2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_keys  <= '0;
            r_dec   <= 1'b0;
            r_pass  <= '0;
            r_round <= '0;
        end else if (abort && r_state != S_IDLE) begin
            r_state <= S_IDLE;
            r_pass  <= '0;
            r_round <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (load && !abort) begin
                        r_keys  <= keys;
                        r_dec   <= decrypt;
                        r_pass  <= '0;
                        r_round <= '0;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_round <= '0;
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    if (w_xfer) begin
                        if (!w_last_rnd) begin
                            r_round <= r_round + 4'd1;
                        end else if (!w_last_pass) begin
                            r_pass  <= r_pass + 2'd1;
                            r_round <= '0;
                            r_state <= S_PREP;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_pass  <= '0;
                    r_round <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign subkey       = w_valid ? w_pc2 : '0;
    assign subkey_valid = w_valid;
    assign round_idx    = r_round;
    assign pass_idx     = r_pass;
    assign busy         = (r_state != S_IDLE);
    assign pass_decrypt = busy && w_pass_dec;
    assign last_round   = w_valid && w_last_rnd;
    assign done         = (r_state == S_DONE);

endmodule

// File: tb/tb_tdes_key_sched.sv
// Self-checking bench for tdes_key_sched: vector table plus
// scoreboard of expected subkeys from an independent DES model.
module tb_tdes_key_sched;

    localparam logic [63:0] K  = 64'h1334_5779_9BBC_DFF1;
    localparam logic [47:0] SA = 48'h1B02_EFFC_7072;
    localparam logic [47:0] SZ = 48'hCB3D_8B0E_17F5;

    localparam int EV_NONE  = 0;
    localparam int EV_GLTCH = 1;
    localparam int EV_ABORT = 2;
    localparam int EV_RST   = 3;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    typedef struct packed {
        logic [47:0] sk;
        logic [3:0]  r;
        logic [1:0]  p;
        logic        pd;
    } exp_t;

    typedef struct {
        logic [191:0] k;
        logic         dec;
        int           rmode;
        int           ev;
        logic [47:0]  e0, e15, e16, e32, e47;
        int           edone;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst, load, decrypt, abort, subkey_ready;
    logic [191:0] keys;
    logic [47:0]  subkey;
    logic         subkey_valid, pass_decrypt, last_round, busy, done;
    logic [3:0]   round_idx;
    logic [1:0]   pass_idx;

    exp_t        q[$];
    logic [47:0] obs [48];
    int          n_obs;
    int          n_cmp = 0;
    int          n_err = 0;

    tdes_key_sched #(.NUM_PASSES(3), .ROUNDS(16)) dut (
        .clk(clk), .rst(rst), .load(load), .keys(keys),
        .decrypt(decrypt), .abort(abort),
        .subkey_ready(subkey_ready), .subkey(subkey),
        .subkey_valid(subkey_valid), .round_idx(round_idx),
        .pass_idx(pass_idx), .pass_decrypt(pass_decrypt),
        .last_round(last_round), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Subkey n (1..16) by cumulative left shifts from C0/D0.
    function automatic logic [47:0] ks(input logic [63:0] k, input int n);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] o;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = k[6'(64 - PC1[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int j = 0; j < n; j++) begin
            for (int s = 0; s < SH[j]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2[i])];
        return o;
    endfunction

    task automatic push_exp(input logic [191:0] k, input logic dec);
        logic [63:0] kk;
        logic        pd;
        for (int p = 0; p < 3; p++) begin
            kk = dec ? k[64*p +: 64] : k[64*(2-p) +: 64];
            pd = dec ^ (p == 1);
            for (int r = 0; r < 16; r++) begin
                q.push_back('{ks(kk, pd ? 16 - r : r + 1),
                              4'(r), 2'(p), pd});
            end
        end
    endtask

    task automatic run(input logic [191:0] k, input logic dec,
                       input int rmode, input int ev, output int dcyc);
        int          c;
        int          stop;
        logic        stalled, bad;
        logic [47:0] p_sk;
        logic [3:0]  p_r;
        logic [1:0]  p_p;
        exp_t        e;
        q.delete();
        push_exp(k, dec);
        n_obs   = 0;
        dcyc    = -1;
        stop    = 0;
        stalled = 1'b0;
        p_sk = '0; p_r = '0; p_p = '0;
        keys = k; decrypt = dec; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        keys = ~k;
        decrypt = ~dec;
        c = 1;
        while (c < 400 && stop == 0) begin
            subkey_ready = (rmode == 0) || (c % 4 == 0) || (c % 4 == 3);
            load = (ev == EV_GLTCH) && (c == 8 || c == 9);
            if (stalled) begin
                chk("hold", {subkey_valid, subkey, round_idx, pass_idx},
                    {1'b1, p_sk, p_r, p_p});
            end
            if (subkey_valid) begin
                chk("last_round", last_round, round_idx == 4'd15);
            end
            if (ev == EV_ABORT && subkey_valid && pass_idx == 2'd1
                && round_idx == 4'd5) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_idle", {subkey_valid, busy, done, subkey},
                    '0);
                bad = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    if (done || busy) bad = 1'b1;
                end
                chk("abort_no_done", bad, 1'b0);
                stop = 2;
            end else if (ev == EV_RST && subkey_valid && pass_idx == 2'd2
                         && round_idx == 4'd10) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_outputs", {subkey, subkey_valid, round_idx,
                    pass_idx, pass_decrypt, last_round, busy, done}, '0);
                bad = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    if (busy) bad = 1'b1;
                end
                chk("rst_stays_idle", bad, 1'b0);
                stop = 2;
            end else begin
                if (subkey_valid && subkey_ready) begin
                    if (q.size() == 0) begin
                        chk("extra_subkey", subkey, '0);
                    end else begin
                        e = q.pop_front();
                        chk("scoreboard", {subkey, round_idx, pass_idx,
                            pass_decrypt}, e);
                        if (n_obs < 48) obs[n_obs] = subkey;
                        n_obs++;
                    end
                end
                if (done) begin
                    dcyc = c;
                    chk("queue_empty_at_done", 64'(q.size()), 0);
                    stop = 1;
                end else begin
                    stalled = subkey_valid && !subkey_ready;
                    p_sk = subkey; p_r = round_idx; p_p = pass_idx;
                    @(negedge clk);
                    c++;
                end
            end
        end
        load = 1'b0;
        subkey_ready = 1'b0;
        if (stop == 0) chk("done_timeout", 1, 0);
        if (stop == 1) begin
            @(negedge clk);
            chk("done_one_cycle", {done, busy}, 2'b00);
        end
        q.delete();
    endtask

    vec_t tv [5];
    int   dc;

    initial begin
        tv[0] = '{{K, K, K}, 1'b0, 0, EV_NONE, SA, SZ, SZ, SA, SZ, 52};
        tv[1] = '{{K, 64'h0, 64'h0}, 1'b1, 0, EV_NONE,
                  48'h0, 48'h0, 48'h0, SZ, SA, 52};
        tv[2] = '{{K, K, K}, 1'b0, 1, EV_NONE, SA, SZ, SZ, SA, SZ, -1};
        tv[3] = '{{K, K, K}, 1'b0, 0, EV_GLTCH, SA, SZ, SZ, SA, SZ, 52};
        tv[4] = '{{64'h0, 64'h0, K}, 1'b1, 1, EV_NONE,
                  SZ, SA, 48'h0, 48'h0, 48'h0, -1};

        rst = 1'b1; load = 1'b0; keys = '0; decrypt = 1'b0;
        abort = 1'b0; subkey_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {subkey, subkey_valid, round_idx, pass_idx,
            pass_decrypt, last_round, busy, done}, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_idle", busy, 1'b0);

        for (int i = 0; i < 5; i++) begin
            run(tv[i].k, tv[i].dec, tv[i].rmode, tv[i].ev, dc);
            chk("subkey_count", 64'(n_obs), 48);
            if (tv[i].edone >= 0) chk("done_cycle", 64'(dc), 64'(tv[i].edone));
            if (n_obs == 48) begin
                chk("kat_p0_first", obs[0],  tv[i].e0);
                chk("kat_p0_last",  obs[15], tv[i].e15);
                chk("kat_p1_first", obs[16], tv[i].e16);
                chk("kat_p2_first", obs[32], tv[i].e32);
                chk("kat_p2_last",  obs[47], tv[i].e47);
            end
        end

        run({K, K, K}, 1'b0, 0, EV_ABORT, dc);
        chk("abort_partial_count", 64'(n_obs), 21);
        run({K, 64'h0, K}, 1'b0, 0, EV_NONE, dc);
        chk("after_abort_done", 64'(dc), 52);
        chk("after_abort_first", obs[0], SA);

        run({K, K, K}, 1'b1, 0, EV_RST, dc);
        chk("rst_partial_count", 64'(n_obs), 42);
        run({K, K, K}, 1'b1, 0, EV_NONE, dc);
        chk("after_rst_done", 64'(dc), 52);
        chk("after_rst_first", obs[0], SZ);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
